// File: rtl/store_buffer_be.sv
// Byte-enable store buffer: in-order allocate/drain ring, out-of-order execute, byte-granular load forwarding.
// Optional STORE_BUFFER_BYTE_MERGE_EN: each forwarded byte comes from the youngest older store covering it.
module store_buffer_be #(
   parameter  int SB_DEPTH      = 16,
   parameter  int ALLOC_WIDTH   = 4,
   parameter  int COMMIT_WIDTH  = 4,
   parameter  int ROB_IDX_WIDTH = 6,
   parameter  int PLEN          = 32,
   parameter  int XLEN          = 32,
   localparam int NB            = XLEN / 8,
   localparam int IDW           = $clog2(SB_DEPTH)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [ALLOC_WIDTH-1:0]        alloc_req_i,
   output logic                          alloc_ready_o,
   output logic [ALLOC_WIDTH*IDW-1:0]    alloc_id_o,
   input  logic                          alloc_fire_i,
   input  logic                          ex_valid_i,
   input  logic [IDW-1:0]                ex_sb_id_i,
   input  logic [PLEN-1:0]               ex_addr_i,
   input  logic [XLEN-1:0]               ex_data_i,
   input  logic [1:0]                    ex_op_i,
   input  logic [ROB_IDX_WIDTH-1:0]      ex_rob_idx_i,
   input  logic [COMMIT_WIDTH-1:0]       commit_valid_i,
   input  logic [COMMIT_WIDTH*IDW-1:0]   commit_sb_id_i,
   output logic                          dcache_req_valid_o,
   input  logic                          dcache_req_ready_i,
   output logic [PLEN-1:0]               dcache_req_addr_o,
   output logic [XLEN-1:0]               dcache_req_data_o,
   output logic [NB-1:0]                 dcache_req_be_o,
   input  logic                          load_valid_i,
   input  logic [PLEN-1:0]               load_addr_i,
   input  logic [1:0]                    load_op_i,
   input  logic [ROB_IDX_WIDTH-1:0]      load_rob_idx_i,
   input  logic [ROB_IDX_WIDTH-1:0]      rob_head_i,
   output logic [NB-1:0]                 load_fwd_be_o,
   output logic [XLEN-1:0]               load_fwd_data_o,
   output logic                          load_hit_o,
   output logic                          load_stall_o,
   input  logic                          flush_i,
   output logic [IDW:0]                  count_o,
   output logic                          empty_o
);

   localparam int OFFW = $clog2(NB);
   localparam int WAW  = PLEN - OFFW;
   localparam int CW   = IDW + 2;

   // Memory-op size encoding shared by ex_op_i and load_op_i; anything else is a doubleword.
   localparam logic [1:0] OP_SB = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SW = 2'd2;

   function automatic logic [NB-1:0] f_op_mask(input logic [1:0] op, input logic [OFFW-1:0] off);
      logic [NB-1:0] m;
      case (op)
         OP_SB:   m = NB'(1);
         OP_SH:   m = NB'(3);
         OP_SW:   m = NB'(15);
         default: m = NB'(255);
      endcase
      return m << off;
   endfunction

   function automatic logic [ROB_IDX_WIDTH-1:0] f_rob_age(input logic [ROB_IDX_WIDTH-1:0] idx,
                                                          input logic [ROB_IDX_WIDTH-1:0] head);
      return idx - head;
   endfunction

   logic [SB_DEPTH-1:0]      r_valid;
   logic [SB_DEPTH-1:0]      r_committed;
   logic [SB_DEPTH-1:0]      r_addr_valid;
   logic [WAW-1:0]           r_waddr [SB_DEPTH];
   logic [NB-1:0]            r_be    [SB_DEPTH];
   logic [XLEN-1:0]          r_data  [SB_DEPTH];
   logic [ROB_IDX_WIDTH-1:0] r_rob   [SB_DEPTH];
   logic [IDW-1:0]           r_head;
   logic [IDW-1:0]           r_tail;
   logic [IDW:0]             r_count;

   logic [IDW:0]             w_alloc_n;
   logic [IDW:0]             w_alloc_add;
   logic [CW-1:0]            w_need;
   logic                     w_do_alloc;
   logic                     w_ex_do;
   logic                     w_drain;
   logic [SB_DEPTH-1:0]      w_commit_set;
   logic [SB_DEPTH-1:0]      w_keep;
   logic [IDW:0]             w_keep_cnt;
   logic [SB_DEPTH-1:0]      w_valid_nx;
   logic [SB_DEPTH-1:0]      w_comm_nx;
   logic [SB_DEPTH-1:0]      w_av_nx;
   logic [NB-1:0]            w_ld_mask;
   logic [WAW-1:0]           w_ld_waddr;
   logic [ROB_IDX_WIDTH-1:0] w_ld_age;
   logic [SB_DEPTH-1:0]      w_fwd_match;
   logic [IDW-1:0]           w_scan_idx;

   // Slot i takes the tail plus the number of requesting slots below it.
   always_comb begin
      w_alloc_n  = '0;
      alloc_id_o = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         if (alloc_req_i[i]) begin
            alloc_id_o[i*IDW +: IDW] = r_tail + w_alloc_n[IDW-1:0];
            w_alloc_n = w_alloc_n + (IDW+1)'(1);
         end
      end
   end

   assign w_need        = CW'(r_count) + CW'(w_alloc_n);
   assign alloc_ready_o = (w_need <= CW'(SB_DEPTH));
   assign w_do_alloc    = alloc_fire_i & alloc_ready_o & ~flush_i;
   assign w_alloc_add   = w_do_alloc ? w_alloc_n : '0;
   assign w_ex_do       = ex_valid_i & r_valid[ex_sb_id_i] & ~flush_i;

   always_comb begin
      w_commit_set = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (commit_valid_i[j]) w_commit_set[commit_sb_id_i[j*IDW +: IDW]] = 1'b1;
      end
   end

   // Flush survivors: already senior, or becoming senior this very cycle.
   assign w_keep = r_valid & (r_committed | w_commit_set);

   always_comb begin
      w_keep_cnt = '0;
      for (int e = 0; e < SB_DEPTH; e++) w_keep_cnt = w_keep_cnt + (IDW+1)'(w_keep[e]);
   end

   assign dcache_req_valid_o = r_valid[r_head] & r_committed[r_head] & r_addr_valid[r_head];
   assign dcache_req_addr_o  = {r_waddr[r_head], {OFFW{1'b0}}};
   assign dcache_req_data_o  = r_data[r_head];
   assign dcache_req_be_o    = r_be[r_head];
   assign w_drain            = dcache_req_valid_o & dcache_req_ready_i;

   always_comb begin
      w_valid_nx = r_valid;
      w_comm_nx  = r_committed | (w_commit_set & r_valid);
      w_av_nx    = r_addr_valid;
      if (flush_i) begin
         w_valid_nx = r_valid & w_keep;
         w_comm_nx  = w_comm_nx & w_keep;
         w_av_nx    = r_addr_valid & w_keep;
      end else begin
         if (w_do_alloc) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
               if (alloc_req_i[i]) begin
                  w_valid_nx[alloc_id_o[i*IDW +: IDW]] = 1'b1;
                  w_comm_nx[alloc_id_o[i*IDW +: IDW]]  = 1'b0;
                  w_av_nx[alloc_id_o[i*IDW +: IDW]]    = 1'b0;
               end
            end
         end
         if (w_ex_do) w_av_nx[ex_sb_id_i] = 1'b1;
      end
      if (w_drain) begin
         w_valid_nx[r_head] = 1'b0;
         w_comm_nx[r_head]  = 1'b0;
         w_av_nx[r_head]    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid      <= '0;
         r_committed  <= '0;
         r_addr_valid <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
      end else begin
         r_valid      <= w_valid_nx;
         r_committed  <= w_comm_nx;
         r_addr_valid <= w_av_nx;
         if (w_drain) r_head <= r_head + IDW'(1);
         if (flush_i) begin
            r_tail  <= r_head + w_keep_cnt[IDW-1:0];
            r_count <= w_keep_cnt - (IDW+1)'(w_drain);
         end else begin
            r_tail  <= r_tail + w_alloc_add[IDW-1:0];
            r_count <= r_count + w_alloc_add - (IDW+1)'(w_drain);
         end
      end
   end

   // Payload is only meaningful behind addr_valid, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (w_ex_do) begin
         r_waddr[ex_sb_id_i] <= ex_addr_i[PLEN-1:OFFW];
         r_be[ex_sb_id_i]    <= f_op_mask(ex_op_i, ex_addr_i[OFFW-1:0]);
         r_data[ex_sb_id_i]  <= ex_data_i << {ex_addr_i[OFFW-1:0], 3'b000};
         r_rob[ex_sb_id_i]   <= ex_rob_idx_i;
      end
   end

   assign count_o    = r_count;
   assign empty_o    = (r_count == '0);
   assign w_ld_mask  = f_op_mask(load_op_i, load_addr_i[OFFW-1:0]);
   assign w_ld_waddr = load_addr_i[PLEN-1:OFFW];
   assign w_ld_age   = f_rob_age(load_rob_idx_i, rob_head_i);

   always_comb begin
      w_fwd_match = '0;
      for (int e = 0; e < SB_DEPTH; e++) begin
         w_fwd_match[e] = r_valid[e] && r_addr_valid[e] &&
                          (r_committed[e] || (f_rob_age(r_rob[e], rob_head_i) < w_ld_age)) &&
                          (r_waddr[e] == w_ld_waddr) && ((r_be[e] & w_ld_mask) != '0);
      end
   end

`ifdef STORE_BUFFER_BYTE_MERGE_EN
   logic [NB-1:0]   w_m_be;
   logic [XLEN-1:0] w_m_data;

   // Scan oldest to youngest so later matches overwrite earlier ones byte by byte.
   always_comb begin
      w_m_be     = '0;
      w_m_data   = '0;
      w_scan_idx = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         w_scan_idx = r_head + IDW'(k);
         if (w_fwd_match[w_scan_idx]) begin
            for (int b = 0; b < NB; b++) begin
               if (r_be[w_scan_idx][b] && w_ld_mask[b]) begin
                  w_m_be[b]          = 1'b1;
                  w_m_data[b*8 +: 8] = r_data[w_scan_idx][b*8 +: 8];
               end
            end
         end
      end
   end

   assign load_fwd_be_o   = load_valid_i ? w_m_be : '0;
   assign load_fwd_data_o = load_valid_i ? w_m_data : '0;
   assign load_hit_o      = load_valid_i && (w_m_be == w_ld_mask);
   assign load_stall_o    = 1'b0;
`else
   logic            w_sel_found;
   logic [IDW-1:0]  w_sel_idx;
   logic            w_sel_full;
   logic [XLEN-1:0] w_sel_data;

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_scan_idx  = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         w_scan_idx = r_head + IDW'(k);
         if (w_fwd_match[w_scan_idx]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_scan_idx;
         end
      end
   end

   assign w_sel_full = ((r_be[w_sel_idx] & w_ld_mask) == w_ld_mask);

   always_comb begin
      w_sel_data = '0;
      for (int b = 0; b < NB; b++) begin
         if (w_ld_mask[b]) w_sel_data[b*8 +: 8] = r_data[w_sel_idx][b*8 +: 8];
      end
   end

   // A youngest store that only partly covers the load forces a replay.
   assign load_hit_o      = load_valid_i & w_sel_found & w_sel_full;
   assign load_stall_o    = load_valid_i & w_sel_found & ~w_sel_full;
   assign load_fwd_be_o   = load_hit_o ? w_ld_mask : '0;
   assign load_fwd_data_o = load_hit_o ? w_sel_data : '0;
`endif

endmodule

// File: tb/tb_store_buffer_be.sv
// Scoreboard bench for store_buffer_be: drains checked against a queue of expected stores,
// plus direct checks of allocation, occupancy, flush and load forwarding.
module tb_store_buffer_be;

   localparam logic [1:0] SB = 2'd0;
   localparam logic [1:0] SH = 2'd1;
   localparam logic [1:0] SW = 2'd2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } drn_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [3:0]  alloc_req_i;
   logic        alloc_ready_o;
   logic [15:0] alloc_id_o;
   logic        alloc_fire_i;
   logic        ex_valid_i;
   logic [3:0]  ex_sb_id_i;
   logic [31:0] ex_addr_i;
   logic [31:0] ex_data_i;
   logic [1:0]  ex_op_i;
   logic [5:0]  ex_rob_idx_i;
   logic [3:0]  commit_valid_i;
   logic [15:0] commit_sb_id_i;
   logic        dcache_req_valid_o;
   logic        dcache_req_ready_i;
   logic [31:0] dcache_req_addr_o;
   logic [31:0] dcache_req_data_o;
   logic [3:0]  dcache_req_be_o;
   logic        load_valid_i;
   logic [31:0] load_addr_i;
   logic [1:0]  load_op_i;
   logic [5:0]  load_rob_idx_i;
   logic [5:0]  rob_head_i;
   logic [3:0]  load_fwd_be_o;
   logic [31:0] load_fwd_data_o;
   logic        load_hit_o;
   logic        load_stall_o;
   logic        flush_i;
   logic [4:0]  count_o;
   logic        empty_o;

   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_drained = 0;
   drn_t q_exp[$];
   drn_t m_exp;

   always #5 clk_i = ~clk_i;

   store_buffer_be dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alloc_req_i(alloc_req_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
      .alloc_fire_i(alloc_fire_i),
      .ex_valid_i(ex_valid_i), .ex_sb_id_i(ex_sb_id_i), .ex_addr_i(ex_addr_i),
      .ex_data_i(ex_data_i), .ex_op_i(ex_op_i), .ex_rob_idx_i(ex_rob_idx_i),
      .commit_valid_i(commit_valid_i), .commit_sb_id_i(commit_sb_id_i),
      .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_ready_i(dcache_req_ready_i),
      .dcache_req_addr_o(dcache_req_addr_o), .dcache_req_data_o(dcache_req_data_o),
      .dcache_req_be_o(dcache_req_be_o),
      .load_valid_i(load_valid_i), .load_addr_i(load_addr_i), .load_op_i(load_op_i),
      .load_rob_idx_i(load_rob_idx_i), .rob_head_i(rob_head_i),
      .load_fwd_be_o(load_fwd_be_o), .load_fwd_data_o(load_fwd_data_o),
      .load_hit_o(load_hit_o), .load_stall_o(load_stall_o),
      .flush_i(flush_i), .count_o(count_o), .empty_o(empty_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every handshake must match the oldest outstanding expected store.
   always @(negedge clk_i) begin
      if (rst_ni && dcache_req_valid_o && dcache_req_ready_i) begin
         if (q_exp.size() == 0) begin
            chk("drain_unexpected", 64'h1, 64'h0);
         end else begin
            m_exp = q_exp.pop_front();
            chk("drain_addr", 64'(dcache_req_addr_o), 64'(m_exp.a));
            chk("drain_data", 64'(dcache_req_data_o), 64'(m_exp.d));
            chk("drain_be",   64'(dcache_req_be_o),   64'(m_exp.be));
         end
         n_drained++;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_alloc(input logic [3:0] req);
      alloc_req_i  = req;
      alloc_fire_i = 1'b1;
      tick();
      alloc_req_i  = '0;
      alloc_fire_i = 1'b0;
   endtask

   task automatic do_exec(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] op, input logic [5:0] rob);
      ex_valid_i   = 1'b1;
      ex_sb_id_i   = id;
      ex_addr_i    = addr;
      ex_data_i    = data;
      ex_op_i      = op;
      ex_rob_idx_i = rob;
      tick();
      ex_valid_i   = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] vld, input logic [15:0] ids);
      commit_valid_i = vld;
      commit_sb_id_i = ids;
      tick();
      commit_valid_i = '0;
   endtask

   task automatic expect_drain(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      q_exp.push_back('{a: a, d: d, be: be});
   endtask

   task automatic drain_wait(input int n);
      int target;
      target = n_drained + n;
      dcache_req_ready_i = 1'b1;
      for (int c = 0; c < 40 && n_drained < target; c++) tick();
      dcache_req_ready_i = 1'b0;
      chk("drain_count", 64'(n_drained), 64'(target));
   endtask

   task automatic chk_load(input string tag, input logic [31:0] addr, input logic [1:0] op,
                           input logic [5:0] rob, input logic [3:0] be, input logic [31:0] data,
                           input logic hit, input logic stall);
      load_valid_i   = 1'b1;
      load_addr_i    = addr;
      load_op_i      = op;
      load_rob_idx_i = rob;
      #1;
      chk({tag, "_be"},    64'(load_fwd_be_o),   64'(be));
      chk({tag, "_data"},  64'(load_fwd_data_o), 64'(data));
      chk({tag, "_hit"},   64'(load_hit_o),      64'(hit));
      chk({tag, "_stall"}, 64'(load_stall_o),    64'(stall));
      load_valid_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0;
      alloc_req_i = '0; alloc_fire_i = 1'b0;
      ex_valid_i = 1'b0; ex_sb_id_i = '0; ex_addr_i = '0; ex_data_i = '0; ex_op_i = '0; ex_rob_idx_i = '0;
      commit_valid_i = '0; commit_sb_id_i = '0; dcache_req_ready_i = 1'b0;
      load_valid_i = 1'b0; load_addr_i = '0; load_op_i = '0; load_rob_idx_i = '0; rob_head_i = '0;
      flush_i = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      tick();

      // Reset state
      chk("rst_count",     64'(count_o),            64'h0);
      chk("rst_empty",     64'(empty_o),            64'h1);
      chk("rst_ready",     64'(alloc_ready_o),      64'h1);
      chk("rst_dc_valid",  64'(dcache_req_valid_o), 64'h0);
      chk("rst_hit",       64'(load_hit_o),         64'h0);
      chk("rst_stall",     64'(load_stall_o),       64'h0);
      chk("rst_fwd_be",    64'(load_fwd_be_o),      64'h0);

      // Sparse allocation request 4'b1011
      alloc_req_i  = 4'b1011;
      alloc_fire_i = 1'b1;
      #1;
      chk("alloc_id0", 64'(alloc_id_o[3:0]),   64'h0);
      chk("alloc_id1", 64'(alloc_id_o[7:4]),   64'h1);
      chk("alloc_id2", 64'(alloc_id_o[11:8]),  64'h0);
      chk("alloc_id3", 64'(alloc_id_o[15:12]), 64'h2);
      tick();
      alloc_req_i  = '0;
      alloc_fire_i = 1'b0;
      chk("alloc_count3", 64'(count_o), 64'h3);
      chk("alloc_nempty", 64'(empty_o), 64'h0);

      // Full word, top byte, and a halfword executed after its commit
      do_exec(4'd0, 32'h1000, 32'hAABBCCDD, SW, 6'd0);
      do_exec(4'd1, 32'h1003, 32'h00000011, SB, 6'd1);
      chk("no_drain_uncommitted", 64'(dcache_req_valid_o), 64'h0);
      expect_drain(32'h1000, 32'hAABBCCDD, 4'b1111);
      expect_drain(32'h1000, 32'h11000000, 4'b1000);
      expect_drain(32'h1004, 32'hBEEF0000, 4'b1100);
      do_commit(4'b0111, {4'd0, 4'd2, 4'd1, 4'd0});
      chk("drain_valid", 64'(dcache_req_valid_o), 64'h1);
      tick();
      chk("hold_addr", 64'(dcache_req_addr_o), 64'h1000);
      chk("hold_data", 64'(dcache_req_data_o), 64'hAABBCCDD);
      drain_wait(2);
      chk("wait_exec_valid", 64'(dcache_req_valid_o), 64'h0);
      chk("wait_exec_count", 64'(count_o),            64'h1);
      do_exec(4'd2, 32'h1006, 32'h0000BEEF, SH, 6'd2);
      drain_wait(1);
      chk("t1_empty", 64'(empty_o), 64'h1);

      // Reset pointers, then fill to capacity
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) do_alloc(4'b1111);
      chk("full_count", 64'(count_o), 64'd16);
      alloc_req_i = 4'b0001;
      #1;
      chk("full_not_ready", 64'(alloc_ready_o), 64'h0);
      alloc_req_i = 4'b0000;
      #1;
      chk("full_n0_ready", 64'(alloc_ready_o), 64'h1);
      do_exec(4'd0, 32'h3000, 32'h01020304, SW, 6'd0);
      expect_drain(32'h3000, 32'h01020304, 4'b1111);
      do_commit(4'b0001, 16'h0000);
      drain_wait(1);
      chk("after_drain_count", 64'(count_o), 64'd15);
      alloc_req_i = 4'b0001;
      #1;
      chk("after_drain_ready", 64'(alloc_ready_o),   64'h1);
      chk("wrap_id",           64'(alloc_id_o[3:0]), 64'h0);
      do_alloc(4'b0001);
      chk("refill_count", 64'(count_o), 64'd16);

      // Reset while the second committed store is waiting at the head
      do_exec(4'd1, 32'h3004, 32'h00000055, SW, 6'd1);
      do_exec(4'd2, 32'h3008, 32'h00000066, SW, 6'd2);
      expect_drain(32'h3004, 32'h00000055, 4'b1111);
      expect_drain(32'h3008, 32'h00000066, 4'b1111);
      do_commit(4'b0011, {8'h00, 4'd2, 4'd1});
      drain_wait(1);
      chk("pre_rst_valid", 64'(dcache_req_valid_o), 64'h1);
      rst_ni = 1'b0;
      q_exp.delete();
      #1;
      chk("mid_rst_valid", 64'(dcache_req_valid_o), 64'h0);
      chk("mid_rst_count", 64'(count_o),            64'h0);
      tick();
      rst_ni = 1'b1;
      tick();

      // Forwarding: older SW 0x2000, younger SB 0x2001
      do_alloc(4'b0011);
      do_exec(4'd0, 32'h2000, 32'h12345678, SW, 6'd5);
      do_exec(4'd1, 32'h2001, 32'h000000EE, SB, 6'd6);
`ifdef STORE_BUFFER_BYTE_MERGE_EN
      chk_load("ld_merge",  32'h2000, SW, 6'd10, 4'b1111, 32'h1234EE78, 1'b1, 1'b0);
`else
      chk_load("ld_partial", 32'h2000, SW, 6'd10, 4'b0000, 32'h00000000, 1'b0, 1'b1);
`endif
      chk_load("ld_byte",    32'h2001, SB, 6'd10, 4'b0010, 32'h0000EE00, 1'b1, 1'b0);
      chk_load("ld_half",    32'h2002, SH, 6'd10, 4'b1100, 32'h12340000, 1'b1, 1'b0);
      chk_load("ld_younger", 32'h2000, SW, 6'd5,  4'b0000, 32'h00000000, 1'b0, 1'b0);
      chk_load("ld_other",   32'h2004, SW, 6'd10, 4'b0000, 32'h00000000, 1'b0, 1'b0);
      rob_head_i = 6'd60;
      chk_load("ld_wrap_young", 32'h2000, SW, 6'd2, 4'b0000, 32'h00000000, 1'b0, 1'b0);
      rob_head_i = 6'd0;
      load_addr_i = 32'h2000;
      load_op_i   = SW;
      load_rob_idx_i = 6'd10;
      #1;
      chk("ld_idle_be",    64'(load_fwd_be_o), 64'h0);
      chk("ld_idle_hit",   64'(load_hit_o),    64'h0);
      chk("ld_idle_stall", 64'(load_stall_o),  64'h0);
      expect_drain(32'h2000, 32'h12345678, 4'b1111);
      do_commit(4'b0001, 16'h0000);
      chk_load("ld_committed", 32'h2000, SW, 6'd5, 4'b1111, 32'h12345678, 1'b1, 1'b0);
      expect_drain(32'h2000, 32'h0000EE00, 4'b0010);
      do_commit(4'b0001, 16'h0001);
      drain_wait(2);
      chk("t3_empty", 64'(empty_o), 64'h1);

      // Flush: ids 2..4 committed, 5 commits during the flush, 6 squashed
      do_alloc(4'b1111);
      do_alloc(4'b0001);
      for (int k = 0; k < 5; k++) do_exec(4'(k + 2), 32'h4000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), SW, 6'(k));
      for (int k = 0; k < 3; k++) expect_drain(32'h4000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'b1111);
      do_commit(4'b0111, {4'd0, 4'd4, 4'd3, 4'd2});
      expect_drain(32'h400C, 32'hC0DE0003, 4'b1111);
      flush_i        = 1'b1;
      commit_valid_i = 4'b0001;
      commit_sb_id_i = 16'h0005;
      alloc_req_i    = 4'b0001;
      alloc_fire_i   = 1'b1;
      tick();
      flush_i = 1'b0; commit_valid_i = '0; alloc_req_i = '0; alloc_fire_i = 1'b0;
      chk("flush_count", 64'(count_o), 64'h4);
      drain_wait(4);
      chk("flush_empty",  64'(empty_o),            64'h1);
      chk("flush_no_req", 64'(dcache_req_valid_o), 64'h0);
      alloc_req_i = 4'b0001;
      #1;
      chk("flush_tail", 64'(alloc_id_o[3:0]), 64'h6);
      alloc_req_i = '0;
      chk("sb_leftover", 64'(q_exp.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
